// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline boundary with valid/ready handshake, synchronous flush and control qualification.
// Define EX_MEM_SKID_EN for the two-entry skid buffer with registered EX_ready; otherwise head register only.
module ex_mem_skid_reg #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            EX_valid,
  output logic            EX_ready,
  input  logic [XLEN-1:0] EX_alu_out,
  input  logic [XLEN-1:0] EX_a2,
  input  logic [XLEN-1:0] EX_b2,
  input  logic [RD_W-1:0] EX_rd,
  input  logic            EX_taken,
  input  logic            EX_we,
  input  logic            EX_ld,
  input  logic            EX_str,
  input  logic            EX_byt,
  input  logic            flush,
  output logic            MEM_valid,
  input  logic            MEM_ready,
  output logic [XLEN-1:0] MEM_alu_out,
  output logic [XLEN-1:0] MEM_a2,
  output logic [XLEN-1:0] MEM_b2,
  output logic [RD_W-1:0] MEM_rd,
  output logic            MEM_taken,
  output logic            MEM_we,
  output logic            MEM_ld,
  output logic            MEM_str,
  output logic            MEM_byt,
  output logic [1:0]      occ
);

  localparam int PW = 3*XLEN + RD_W + 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] in_pay, head_pay;
  logic          head_valid, push, pop, load_head_in;
  logic          raw_we, raw_ld, raw_str, raw_byt;

  assign in_pay     = {EX_alu_out, EX_a2, EX_b2, EX_rd, EX_taken, EX_we, EX_ld, EX_str, EX_byt};
  assign head_valid = (state != EMPTY);
  assign pop        = head_valid && MEM_ready;
  assign push       = EX_valid && EX_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

`ifdef EX_MEM_SKID_EN
  logic [PW-1:0] skid_pay;
  logic          load_skid, load_head_skid, ex_ready_q;

  // flush wins over every push/pop; payloads keep their old contents
  always_comb begin
    state_next     = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) begin
          state_next   = ONE;
          load_head_in = 1'b1;
        end
        ONE: begin
          if (push && pop) begin
            load_head_in = 1'b1;
          end else if (push) begin
            state_next = TWO;
            load_skid  = 1'b1;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_next     = ONE;
          load_head_skid = 1'b1;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // EX_ready comes straight from a flop so MEM_ready/flush never reach EX combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ready_q <= 1'b1;
      skid_pay   <= '0;
      head_pay   <= '0;
    end else begin
      ex_ready_q <= (state_next != TWO);
      if (load_skid) skid_pay <= in_pay;
      if (load_head_in)        head_pay <= in_pay;
      else if (load_head_skid) head_pay <= skid_pay;
    end
  end

  assign EX_ready = ex_ready_q;
  assign occ      = (state == TWO) ? 2'd2 : ((state == ONE) ? 2'd1 : 2'd0);
`else
  // in ONE a push implies a pop, because EX_ready then equals MEM_ready
  always_comb begin
    state_next   = state;
    load_head_in = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) begin
          state_next   = ONE;
          load_head_in = 1'b1;
        end
        ONE: begin
          if (push)     load_head_in = 1'b1;
          else if (pop) state_next   = EMPTY;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               head_pay <= '0;
    else if (load_head_in) head_pay <= in_pay;
  end

  assign EX_ready = !head_valid || MEM_ready;
  assign occ      = {1'b0, (state == ONE)};
`endif

  assign {MEM_alu_out, MEM_a2, MEM_b2, MEM_rd, MEM_taken, raw_we, raw_ld, raw_str, raw_byt} = head_pay;

  assign MEM_valid = head_valid;
  assign MEM_we    = raw_we  && head_valid;
  assign MEM_ld    = raw_ld  && head_valid;
  assign MEM_str   = raw_str && head_valid;
  assign MEM_byt   = raw_byt && head_valid;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed self-checking bench for ex_mem_skid_reg; covers both builds via EX_MEM_SKID_EN.
module tb_ex_mem_skid_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_valid, EX_ready;
  logic [31:0] EX_alu_out, EX_a2, EX_b2;
  logic [4:0]  EX_rd;
  logic        EX_taken, EX_we, EX_ld, EX_str, EX_byt;
  logic        flush;
  logic        MEM_valid, MEM_ready;
  logic [31:0] MEM_alu_out, MEM_a2, MEM_b2;
  logic [4:0]  MEM_rd;
  logic        MEM_taken, MEM_we, MEM_ld, MEM_str, MEM_byt;
  logic [1:0]  occ;

  int checks = 0;
  int errors = 0;

  ex_mem_skid_reg #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst),
    .EX_valid(EX_valid), .EX_ready(EX_ready),
    .EX_alu_out(EX_alu_out), .EX_a2(EX_a2), .EX_b2(EX_b2), .EX_rd(EX_rd),
    .EX_taken(EX_taken), .EX_we(EX_we), .EX_ld(EX_ld), .EX_str(EX_str), .EX_byt(EX_byt),
    .flush(flush),
    .MEM_valid(MEM_valid), .MEM_ready(MEM_ready),
    .MEM_alu_out(MEM_alu_out), .MEM_a2(MEM_a2), .MEM_b2(MEM_b2), .MEM_rd(MEM_rd),
    .MEM_taken(MEM_taken), .MEM_we(MEM_we), .MEM_ld(MEM_ld), .MEM_str(MEM_str), .MEM_byt(MEM_byt),
    .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                               input logic we, input logic str, input logic mrdy, input logic fl);
    EX_valid   = v;
    EX_alu_out = alu;
    EX_a2      = alu ^ 32'h100;
    EX_b2      = ~alu;
    EX_rd      = rd;
    EX_taken   = 1'b0;
    EX_we      = we;
    EX_ld      = 1'b0;
    EX_str     = str;
    EX_byt     = 1'b0;
    MEM_ready  = mrdy;
    flush      = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 32'h55, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_valid", MEM_valid, 0);
      checkOutput("rst_we", MEM_we, 0);
      checkOutput("rst_occ", occ, 0);
      checkOutput("rst_ready", EX_ready, 1);
    end
    checkOutput("rst_alu", MEM_alu_out, 0);

    $display("[TB] first push after reset");
    rst = 1'b0;
    applyStimulus(1'b1, 32'h10, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("first_valid", MEM_valid, 1);
    checkOutput("first_alu", MEM_alu_out, 32'h10);
    checkOutput("first_a2", MEM_a2, 32'h110);
    checkOutput("first_we", MEM_we, 1);
    checkOutput("first_occ", occ, 1);
`ifdef EX_MEM_SKID_EN
    checkOutput("first_ready_skid", EX_ready, 1);
`else
    checkOutput("first_ready_comb", EX_ready, 0);
`endif
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("ready_after_mrdy", EX_ready, 1);
    tick();
    checkOutput("pop_valid", MEM_valid, 0);
    checkOutput("pop_we", MEM_we, 0);
    checkOutput("pop_occ", occ, 0);

    $display("[TB] streaming");
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 32'(i), 5'(i), 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("stream_alu", MEM_alu_out, 64'(i));
      checkOutput("stream_valid", MEM_valid, 1);
      checkOutput("stream_occ", occ, 1);
      checkOutput("stream_ready", EX_ready, 1);
    end
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("stream_drain", MEM_valid, 0);

    $display("[TB] back-pressure");
    applyStimulus(1'b1, 32'hA, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("bp_a_alu", MEM_alu_out, 32'hA);
    checkOutput("bp_a_str", MEM_str, 1);
    checkOutput("bp_a_we", MEM_we, 0);
    applyStimulus(1'b1, 32'hB, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("bp_head_alu", MEM_alu_out, 32'hA);
`ifdef EX_MEM_SKID_EN
    checkOutput("bp_occ2", occ, 2);
    checkOutput("bp_ready0", EX_ready, 0);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("bp_b_alu", MEM_alu_out, 32'hB);
    checkOutput("bp_b_occ", occ, 1);
    checkOutput("bp_b_ready", EX_ready, 1);
    checkOutput("bp_b_str", MEM_str, 0);
`else
    checkOutput("bp_occ1", occ, 1);
    checkOutput("bp_ready0", EX_ready, 0);
    applyStimulus(1'b1, 32'hB, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_ready_comb", EX_ready, 1);
    tick();
    checkOutput("bp_b_alu", MEM_alu_out, 32'hB);
    checkOutput("bp_b_occ", occ, 1);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    tick();
    checkOutput("bp_drain", MEM_valid, 0);

    $display("[TB] flush");
    applyStimulus(1'b1, 32'h30, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h70, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
`ifdef EX_MEM_SKID_EN
    checkOutput("fl_pre_occ", occ, 2);
`else
    checkOutput("fl_pre_occ", occ, 1);
`endif
    applyStimulus(1'b1, 32'h90, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("fl_valid", MEM_valid, 0);
    checkOutput("fl_occ", occ, 0);
    checkOutput("fl_we", MEM_we, 0);
    checkOutput("fl_rd_held", MEM_rd, 3);
    checkOutput("fl_ready", EX_ready, 1);
    tick();
    checkOutput("fl_empty_valid", MEM_valid, 0);
    checkOutput("fl_empty_rd", MEM_rd, 3);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("fl_after", MEM_valid, 0);

    $display("[TB] bubble qualification");
    applyStimulus(1'b0, 32'h44, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bub_valid", MEM_valid, 0);
      checkOutput("bub_we", MEM_we, 0);
      checkOutput("bub_str", MEM_str, 0);
    end

    $display("[TB] asynchronous reset mid-transfer");
    applyStimulus(1'b1, 32'h66, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("ar_pre_valid", MEM_valid, 1);
    rst = 1'b1;
    #1;
    checkOutput("ar_valid", MEM_valid, 0);
    checkOutput("ar_occ", occ, 0);
    checkOutput("ar_we", MEM_we, 0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 32'h77, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("ar_push_alu", MEM_alu_out, 32'h77);
    checkOutput("ar_push_valid", MEM_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_reg.md
# ex_mem_skid_reg

Parametrised EX→MEM pipeline boundary with a valid/ready handshake, a synchronous flush, and an optional two-entry skid buffer. It replaces the single-register, stall-held EX/MEM flop bank. The MEM stage can now back-pressure without a combinational ready path into EX. Mispredicted or trapped instructions are squashed in flight. Control outputs are always qualified by valid, so a bubble can never write the register file or memory.

## Interface
Parameters:
- XLEN, 32, datapath width of alu_out, a2 and b2.
- RD_W, 5, destination-register index width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- EX_valid  in  1  EX holds an instruction to hand over.
- EX_ready  out  1  boundary accepts this cycle.
- EX_alu_out, EX_a2, EX_b2  in  XLEN each  data payload.
- EX_rd  in  RD_W  destination register.
- EX_taken, EX_we, EX_ld, EX_str, EX_byt  in  1 each  control payload.
- flush  in  1  squash every held entry and the current input.
- MEM_valid  out  1  MEM-side entry present.
- MEM_ready  in  1  MEM consumes the entry this cycle.
- MEM_alu_out, MEM_a2, MEM_b2, MEM_rd, MEM_taken  out  as inputs  head payload.
- MEM_we, MEM_ld, MEM_str, MEM_byt  out  1 each  head control, ANDed with MEM_valid.
- occ  out  2  entries held (0–2; max 1 without skid).

## Operation
- Transfer in: EX_valid && EX_ready at a rising edge. Transfer out: MEM_valid && MEM_ready at a rising edge.
- Storage is a head register (drives MEM_*) and, with skid enabled, one skid register.
- States with skid: EMPTY (occ=0), ONE (head valid), TWO (head and skid valid).
  - EMPTY, push → ONE.
  - ONE, push without pop → TWO (input goes to skid).
  - ONE, push with pop → ONE (input goes to head).
  - ONE, pop only → EMPTY.
  - TWO, pop → ONE (skid moves to head). No push is possible in TWO.
- Order is strictly FIFO. The skid entry never overtakes the head.
- flush has priority over everything in the same cycle:
  - next state is EMPTY and occ becomes 0.
  - A simultaneous input is discarded, even if EX_ready was 1.
  - A simultaneous pop still counts as consumed by MEM. MEM is flushed by the same controller.
- Payload registers load only on capture. They hold value when invalid or flushed. Only the valid bits are cleared.
- MEM_we, MEM_ld, MEM_str and MEM_byt read 0 whenever MEM_valid=0. MEM_taken and the data fields are unqualified.
- Reset value of every output: MEM_valid 0, all MEM_* 0, occ 0, EX_ready 1 (skid build) or 1 via its equation (no-skid build).

## Timing
- Latency: an accepted input appears on MEM_* the next cycle when head is free or popped. Otherwise it waits behind the head.
- Throughput: 1 transfer per cycle with MEM_ready held high.
- With skid: EX_ready = !skid_valid, driven directly from a flop. It has no combinational path from MEM_ready or flush.
- Without skid: EX_ready = !MEM_valid || MEM_ready (combinational).
- Reset is asynchronous assert. Deassertion is synchronous to clk (synchronised externally).
- Reset mid-transfer drops all entries immediately. The first push is accepted at the first edge after deassertion.

## Configuration
- EX_MEM_SKID_EN defined:
  - two-entry skid buffer with registered EX_ready.
  - occ ranges 0–2.
- EX_MEM_SKID_EN undefined:
  - head register only.
  - EX_ready = !MEM_valid || MEM_ready.
  - occ ∈ {0,1}; occ[1] is tied to 0.
- Handshake, flush and qualification semantics are identical in both builds.

## Test plan
- Reset: assert rst for 3 cycles with EX_valid=1 and EX_we=1 → MEM_valid=0, MEM_we=0, occ=0, EX_ready=1 throughout. Push alu_out=0x10 after release → MEM_alu_out=0x10 and MEM_valid=1 one cycle later.
- Streaming: push alu_out 1,2,3,4 on consecutive cycles with MEM_ready=1 → MEM sees 1,2,3,4 on consecutive cycles, EX_ready stays 1, occ=1.
- Back-pressure (skid): MEM_ready=0 and push A=0xA, B=0xB → occ=2 and EX_ready=0 next cycle. Raise MEM_ready → pops A then B in order, EX_ready=1 one cycle after A pops.
- Flush: occ=2 (rd=3, rd=7), then flush with EX_valid=1 and rd=9 → next cycle MEM_valid=0, occ=0, MEM_we=0. rd=9 never appears on MEM.
- Bubble qualification: EX_valid=0 with EX_we=EX_str=1 → MEM_we=MEM_str=0 and MEM_valid=0 indefinitely.
- No-skid build: MEM_ready=0 after one push → EX_ready=0 in the same cycle. Toggle MEM_ready to 1 → EX_ready=1 combinationally, and a push plus pop in the same cycle keeps occ=1.
